instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage, directly upstream of the opcode/funct3 decoder. Holds the PC and issues word reads to instruction memory over a request/grant + response-valid interface. Buffers returned words in a 2-entry FIFO and presents them to decode with a valid/ready handshake. A redirect from execute flushes the FIFO, discards any in-flight response and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset

- iClk  in  1  clock
- iRst  in  1  reset, asynchronous, active-high
- oImemReq  out  1  fetch request valid
- oImemAddr  out  32  fetch address, word aligned
- iImemGnt  in  1  memory accepts the request this cycle (req & gnt = issue)
- iImemRvalid  in  1  response valid, ≥1 cycle after issue, in order
- iImemRdata  in  32  instruction word
- oValid  out  1  oInstr/oPc valid to decode
- iReady  in  1  decode accepts (oValid & iReady = transfer)
- oInstr  out  32  instruction; opcode = oInstr[6:0], funct3 = oInstr[14:12]
- oPc  out  32  address of oInstr
- iRedirect  in  1  squash and refetch
- iRedirectPc  in  32  new PC; bits [1:0] ignored, forced to 0

## Operation
- Reset: all outputs 0, except oImemAddr = RESET_PC. PC = RESET_PC, FIFO empty, state REQ.
- At most one request outstanding. The PC register advances by 4 on each issue, wrapping modulo 2^32.
- FSM:
  - REQ: oImemReq = 1 when FIFO free slots ≥ 1. On req & gnt, go to WAIT.
  - WAIT: oImemReq = 0. On iImemRvalid, push {rdata, pc_of_request} into the FIFO. If a slot remains after the push, re-enter REQ with oImemReq asserted in the same cycle (back-to-back).
  - DROP: waiting for a response that must be discarded. On iImemRvalid, discard it and go to REQ.
- Redirect has priority over everything in the same cycle:
  - FIFO cleared; oValid = 0 from the next cycle; PC = {iRedirectPc[31:2], 2'b00}.
  - From REQ with no issue this cycle: go to REQ.
  - From REQ with req & gnt this cycle: that request is squashed; go to DROP.
  - From WAIT without rvalid: go to DROP. From WAIT with rvalid: the response is discarded; go to REQ.
  - From DROP: stay in DROP (with rvalid: go to REQ); the PC is updated.
  - Handshake: an oValid & iReady in the redirect cycle is not a transfer; decode squashes it.
- FIFO: 2 entries, 64 bits each (instr, pc). oInstr/oPc come from the head. Push and pop in the same cycle are allowed, including when full (pop frees a slot first). Never overflows, because issue requires a free slot counting the outstanding request.
- oInstr and oPc read 0 when oValid = 0.

## Timing
- oImemReq and oImemAddr are driven from registers only; no combinational path from iImemGnt.
- Fetch latency: rvalid in cycle N gives oValid = 1 in cycle N+1.
- Throughput with gnt always 1 and rvalid 1 cycle after issue: one instruction per cycle after fill.
- Restart after redirect in cycle N:
  - Earliest issue of the new PC is cycle N+1 (from REQ).
  - From DROP, issue comes the cycle after the dropped rvalid.
- Reset deassertion: first oImemReq = 1 in the first clock edge's following cycle, oImemAddr = RESET_PC.
- Reset mid-operation: the FIFO and FSM clear immediately. A response arriving after reset for a pre-reset request must be ignored; the memory side is reset by the same iRst, so none arrives.

## Structure
- Shared package riscv_defs:
  - RESET_PC default constant.
  - t_fetch_state enum {REQ, WAIT, DROP}.
  - NOP constant 32'h0000_0013, used by benches.
- One sub-module: fetch_fifo (2-entry, 64-bit):
  - Ports: push, pop, flush, din, dout, empty, free_cnt.
  - Flush has priority over push.

## Test plan
- Reset release, memory returning RESET_PC+4k as data with 1-cycle latency, iReady = 1 → oPc = 0,4,8,… on consecutive cycles, oInstr equals the address.
- iReady = 0 for 5 cycles → FIFO fills to 2, oImemReq drops to 0. Releasing iReady delivers PCs in order with none lost or duplicated.
- iImemGnt held 0 for 3 cycles → oImemAddr stable and oImemReq held at 1. PC advances only after the grant.
- iRedirect to 32'h0000_0103 while WAIT with rvalid arriving 2 cycles later → old response dropped, next oPc = 32'h0000_0100.
- Redirect in the same cycle as rvalid and as oValid & iReady → FIFO empty the next cycle, next delivered oPc = redirect target.
- PC = 32'hFFFF_FFFC fetch → next request address 32'h0000_0000.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared fetch-side definitions: boot address, fetch FSM states and FIFO entry layout.
package riscv_defs;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } t_fetch_state;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } t_fetch_entry;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, decode handshake and redirect.
interface instr_fetch_if;

    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemGnt;
    logic        iImemRvalid;
    logic [31:0] iImemRdata;
    logic        oValid;
    logic        iReady;
    logic [31:0] oInstr;
    logic [31:0] oPc;
    logic        iRedirect;
    logic [31:0] iRedirectPc;

    modport master (
        output oImemReq, oImemAddr, oValid, oInstr, oPc,
        input  iImemGnt, iImemRvalid, iImemRdata, iReady, iRedirect, iRedirectPc
    );

    modport slave (
        input  oImemReq, oImemAddr, oValid, oInstr, oPc,
        output iImemGnt, iImemRvalid, iImemRdata, iReady, iRedirect, iRedirectPc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {instr, pc} pairs; flush wins over push, a pop frees a slot
// for a push in the same cycle.
module fetch_fifo
    import riscv_defs::*;
(
    input  logic         iClk,
    input  logic         iRst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  t_fetch_entry din,
    output t_fetch_entry dout,
    output logic         empty,
    output logic [1:0]   free_cnt
);

    t_fetch_entry mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (cnt_q != 2'd0);
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    // NOTE: the storage array has no reset; an entry is only observed once cnt_q covers it.
    always_ff @(posedge iClk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout     = mem_q[rd_ptr_q];
    assign empty    = (cnt_q == 2'd0);
    assign free_cnt = 2'd2 - cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding memory requests, two-entry
// buffer towards decode, and redirect handling that squashes in-flight responses.
module instr_fetch
    import riscv_defs::*;
#(
    parameter logic [31:0] BOOT_PC = RESET_PC
) (
    input logic           iClk,
    input logic           iRst,
    instr_fetch_if.master bus
);

    t_fetch_state state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_empty;
    logic [1:0]   free_cnt;
    logic [1:0]   free_after;
    logic         back_to_back;
    logic         issue;
    t_fetch_entry fifo_din;
    t_fetch_entry fifo_dout;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.iRedirectPc[1:0];

    // A transfer coinciding with a redirect is squashed by decode, so it must not pop.
    assign fifo_pop  = !fifo_empty && bus.iReady && !bus.iRedirect;
    assign fifo_push = (state_q == WAIT) && bus.iImemRvalid && !bus.iRedirect;

    // The address is always a register; the request may also be raised by a response that
    // leaves a slot free, so the next fetch issues in the same cycle. Grant never feeds back.
    assign back_to_back = fifo_push && ((free_cnt == 2'd2) || ((free_cnt == 2'd1) && fifo_pop));
    assign bus.oImemReq  = req_q || back_to_back;
    assign bus.oImemAddr = pc_q;
    assign issue         = bus.oImemReq && bus.iImemGnt;

    assign free_after = bus.iRedirect ? 2'd2
                                      : free_cnt + {1'b0, fifo_pop} - {1'b0, fifo_push};

    // pc_q has already stepped past the outstanding request when its response returns.
    assign fifo_din = '{instr: bus.iImemRdata, pc: pc_q - 32'd4};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.iRedirect) begin
            pc_d = {bus.iRedirectPc[31:2], 2'b00};
            if (state_q == REQ) begin
                state_d = issue ? DROP : REQ;
            end else begin
                state_d = bus.iImemRvalid ? REQ : DROP;
            end
        end else if (issue) begin
            state_d = WAIT;
            pc_d    = pc_q + 32'd4;
        end else if ((state_q != REQ) && bus.iImemRvalid) begin
            state_d = REQ;
        end
        req_d = (state_d == REQ) && (free_after != 2'd0);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= REQ;
            pc_q    <= BOOT_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
        end
    end

    fetch_fifo u_fifo (
        .iClk     (iClk),
        .iRst     (iRst),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (bus.iRedirect),
        .din      (fifo_din),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .free_cnt (free_cnt)
    );

    assign bus.oValid = !fifo_empty;
    assign bus.oInstr = fifo_empty ? 32'd0 : fifo_dout.instr;
    assign bus.oPc    = fifo_empty ? 32'd0 : fifo_dout.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory model answers each grant with data equal to the
// address after mem_lat cycles; each scenario task checks its own expectations.
module tb_instr_fetch;
    import riscv_defs::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = '0;

    int          mem_lat    = 1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = NOP;
    logic        mem_pend   = 1'b0;
    int          mem_cnt    = 0;
    logic [31:0] mem_addr   = '0;

    assign bus.iImemRvalid = mem_rvalid;
    assign bus.iImemRdata  = mem_rdata;

    always @(posedge clk) begin : imem_model
        logic        issued;
        logic [31:0] addr;
        issued = bus.oImemReq && bus.iImemGnt && !rst;
        addr   = bus.oImemAddr;
        #1;
        mem_rvalid = 1'b0;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (issued) begin
                mem_pend = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = addr;
            end
            if (mem_pend) begin
                if (mem_cnt <= 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_addr;
                    mem_pend   = 1'b0;
                end else begin
                    mem_cnt = mem_cnt - 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic collect(input int n, input string name);
        int got = 0;
        int cyc = 0;
        bus.iReady = 1'b1;
        while (got < n && cyc < 40) begin
            if (bus.oValid === 1'b1) begin
                checks++;
                if (bus.oPc !== exp_pc || bus.oInstr !== exp_pc) begin
                    errors++;
                    $display("FAIL %s: oPc=%h oInstr=%h, expected both %h", name, bus.oPc, bus.oInstr, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_count: got %0d deliveries, expected %0d", name, got, n);
        end
    endtask

    task automatic redirect_to(input logic [31:0] target, input string name);
        bus.iImemGnt = 1'b0;
        bus.iReady   = 1'b1;
        repeat (3) @(negedge clk);
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = target;
        @(negedge clk);
        bus.iRedirect = 1'b0;
        exp_pc = {target[31:2], 2'b00};
        checks++;
        if (bus.oImemReq !== 1'b1 || bus.oImemAddr !== exp_pc || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_restart: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                     name, bus.oImemReq, bus.oImemAddr, bus.oValid, exp_pc);
        end
    endtask

    task automatic test_reset();
        bus.iImemGnt    = 1'b1;
        bus.iReady      = 1'b1;
        bus.iRedirect   = 1'b0;
        bus.iRedirectPc = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.oImemReq !== 1'b0 || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b valid=%b, expected 0 0", bus.oImemReq, bus.oValid);
        end
        checks++;
        if (bus.oImemAddr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_addr: addr=%h, expected %h", bus.oImemAddr, RESET_PC);
        end
        checks++;
        if (bus.oInstr !== 32'd0 || bus.oPc !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: instr=%h pc=%h, expected 0 0", bus.oInstr, bus.oPc);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.oImemReq !== 1'b1 || bus.oImemAddr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h, expected 1 %h", bus.oImemReq, bus.oImemAddr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int cyc = 0;
        exp_pc = RESET_PC;
        while (bus.oValid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        // Once filled, a new instruction must appear on every cycle.
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.oValid !== 1'b1 || bus.oPc !== exp_pc || bus.oInstr !== exp_pc) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b pc=%h instr=%h, expected 1 %h %h",
                         k, bus.oValid, bus.oPc, bus.oInstr, exp_pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bus.iReady = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.oImemReq !== 1'b0 || bus.oValid !== 1'b1 || bus.oPc !== exp_pc) begin
            errors++;
            $display("FAIL backpressure_full: req=%b valid=%b pc=%h, expected 0 1 %h",
                     bus.oImemReq, bus.oValid, bus.oPc, exp_pc);
        end
        collect(4, "backpressure_drain");
    endtask

    task automatic test_gnt_stall();
        redirect_to(32'h0000_0200, "gnt_stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.oImemReq !== 1'b1 || bus.oImemAddr !== 32'h0000_0200) begin
                errors++;
                $display("FAIL gnt_stall_hold_%0d: req=%b addr=%h, expected 1 00000200", i, bus.oImemReq, bus.oImemAddr);
            end
        end
        bus.iImemGnt = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.oImemReq !== 1'b1 || bus.oImemAddr !== 32'h0000_0204) begin
            errors++;
            $display("FAIL gnt_stall_advance: req=%b addr=%h, expected 1 00000204", bus.oImemReq, bus.oImemAddr);
        end
        collect(2, "gnt_stall_data");
    endtask

    task automatic test_redirect_drop();
        redirect_to(32'h0000_0300, "drop");
        mem_lat      = 3;
        bus.iImemGnt = 1'b1;
        @(negedge clk);
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = 32'h0000_0103;
        @(negedge clk);
        bus.iRedirect = 1'b0;
        checks++;
        if (bus.oImemReq !== 1'b0 || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL drop_wait: req=%b valid=%b, expected 0 0", bus.oImemReq, bus.oValid);
        end
        @(negedge clk);
        mem_lat = 1;
        checks++;
        if (bus.oImemReq !== 1'b0 || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL drop_rvalid: req=%b valid=%b, expected 0 0", bus.oImemReq, bus.oValid);
        end
        @(negedge clk);
        checks++;
        if (bus.oImemReq !== 1'b1 || bus.oImemAddr !== 32'h0000_0100 || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL drop_restart: req=%b addr=%h valid=%b, expected 1 00000100 0",
                     bus.oImemReq, bus.oImemAddr, bus.oValid);
        end
        exp_pc = 32'h0000_0100;
        collect(2, "drop_data");
    endtask

    task automatic test_redirect_same_cycle();
        int cyc = 0;
        bus.iImemGnt = 1'b1;
        bus.iReady   = 1'b1;
        while (!(bus.oValid === 1'b1 && mem_rvalid === 1'b1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 20) begin
            errors++;
            $display("FAIL same_cycle_setup: valid=%b with rvalid never seen, expected both 1", bus.oValid);
        end
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = 32'h0000_0400;
        @(negedge clk);
        bus.iRedirect = 1'b0;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oPc !== 32'd0 || bus.oInstr !== 32'd0) begin
            errors++;
            $display("FAIL same_cycle_flush: valid=%b pc=%h instr=%h, expected 0 0 0", bus.oValid, bus.oPc, bus.oInstr);
        end
        checks++;
        if (bus.oImemReq !== 1'b1 || bus.oImemAddr !== 32'h0000_0400) begin
            errors++;
            $display("FAIL same_cycle_req: req=%b addr=%h, expected 1 00000400", bus.oImemReq, bus.oImemAddr);
        end
        exp_pc = 32'h0000_0400;
        collect(3, "same_cycle_data");
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC, "wrap");
        bus.iImemGnt = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.oImemReq !== 1'b1 || bus.oImemAddr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_addr: req=%b addr=%h, expected 1 00000000", bus.oImemReq, bus.oImemAddr);
        end
        collect(2, "wrap_data");
    endtask

    task automatic test_reset_midop();
        bus.iImemGnt = 1'b1;
        bus.iReady   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oImemReq !== 1'b0 || bus.oImemAddr !== RESET_PC) begin
            errors++;
            $display("FAIL midop_reset: valid=%b req=%b addr=%h, expected 0 0 %h",
                     bus.oValid, bus.oImemReq, bus.oImemAddr, RESET_PC);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.oImemReq !== 1'b1 || bus.oImemAddr !== RESET_PC || bus.oValid !== 1'b0) begin
            errors++;
            $display("FAIL midop_restart: req=%b addr=%h valid=%b, expected 1 %h 0",
                     bus.oImemReq, bus.oImemAddr, bus.oValid, RESET_PC);
        end
        exp_pc = RESET_PC;
        collect(3, "midop_data");
    endtask

    initial begin
        bus.iImemGnt    = 1'b0;
        bus.iReady      = 1'b0;
        bus.iRedirect   = 1'b0;
        bus.iRedirectPc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
